// File: rtl/pitch_pkg.sv
// Shared constants for the pitch snapper: target note table, ratio format and FSM states.
// Note periods are in clock cycles, strictly descending so a tie in distance favours the longer period.
package pitch_pkg;

  localparam int          NOTE_COUNT  = 12;
  localparam int          Q_FRAC_BITS = 12;
  localparam logic [15:0] PERIOD_MIN  = 16'd16;
  localparam logic [15:0] PERIOD_MAX  = 16'd4000;
  localparam logic [15:0] UNITY_RATIO = 16'h1000;

  localparam logic [15:0] NOTE_TABLE [0:NOTE_COUNT-1] = '{
    16'd256, 16'd242, 16'd228, 16'd216, 16'd203, 16'd192,
    16'd181, 16'd171, 16'd161, 16'd152, 16'd144, 16'd136
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DIVIDE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; o_done is high during the final step,
// and o_quotient holds the result from the following cycle until the next i_start.
module seq_divider #(
  parameter int DW = 28,
  parameter int VW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_start,
  input  logic [DW-1:0] i_dividend,
  input  logic [VW-1:0] i_divisor,
  output logic          o_done,
  output logic [DW-1:0] o_quotient
);

  localparam int CW = $clog2(DW);

  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [VW-1:0] r_rem;
  logic [VW-1:0] r_div;
  logic [DW-1:0] r_quo;

  logic [VW:0]   w_rem_sh;
  logic          w_ge;
  logic [VW-1:0] w_rem_next;

  // Remainder is always below the divisor, so the shifted value fits in VW+1 bits
  // and the post-subtract value fits back in VW bits.
  assign w_rem_sh   = {r_rem, r_quo[DW-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_div});
  assign w_rem_next = w_ge ? (w_rem_sh[VW-1:0] - r_div) : w_rem_sh[VW-1:0];

  assign o_done     = r_busy && (r_cnt == CW'(DW - 1));
  assign o_quotient = r_quo;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_quo  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_div  <= i_divisor;
      r_quo  <= i_dividend;
    end else if (r_busy) begin
      r_rem <= w_rem_next;
      r_quo <= {r_quo[DW-2:0], w_ge};
      if (o_done) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pitch_snap.sv
// Snaps a measured period to the nearest table note and emits measured/target as Q4.12.
// In-range result NUM_NOTES+29 cycles after capture, out-of-range after 1; input ignored while busy.
module pitch_snap
  import pitch_pkg::*;
#(
  parameter int          NUM_NOTES  = NOTE_COUNT,
  parameter int          FRAC_BITS  = Q_FRAC_BITS,
  parameter logic [15:0] MIN_PERIOD = PERIOD_MIN,
  parameter logic [15:0] MAX_PERIOD = PERIOD_MAX
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] period_in,
  input  logic        period_en,
  output logic [15:0] target_period,
  output logic [15:0] ratio,
  output logic        ratio_valid,
  output logic        out_of_range,
  output logic        busy
);

  localparam int IDX_W = $clog2(NUM_NOTES);
  localparam int DW    = 16 + FRAC_BITS;

  state_t         r_state;
  logic [15:0]    r_p;
  logic [15:0]    r_last;
  logic           r_have;
  logic           r_oor;
  logic [IDX_W-1:0] r_idx;
  logic [15:0]    r_best;
  logic [16:0]    r_best_dist;
  logic [15:0]    r_target;
  logic [15:0]    r_ratio;
  logic           r_valid;
  logic           r_oor_out;

  logic           w_repeat;
  logic           w_in_range;
  logic [15:0]    w_entry;
  logic [16:0]    w_dist;
  logic           w_take;
  logic           w_last;
  logic [15:0]    w_best_next;
  logic           w_div_done;
  logic [DW-1:0]  w_quotient;
  logic [15:0]    w_ratio_sat;

  assign w_repeat   = r_have && (period_in == r_last);
  assign w_in_range = (period_in != 16'd0) && (period_in >= MIN_PERIOD) && (period_in <= MAX_PERIOD);

  assign w_entry     = NOTE_TABLE[r_idx];
  assign w_dist      = (r_p >= w_entry) ? ({1'b0, r_p} - {1'b0, w_entry})
                                        : ({1'b0, w_entry} - {1'b0, r_p});
  assign w_take      = (w_dist < r_best_dist);
  assign w_best_next = w_take ? w_entry : r_best;
  assign w_last      = (r_state == ST_SEARCH) && (r_idx == IDX_W'(NUM_NOTES - 1));

  // The divider launches on the last search cycle using the not-yet-registered winner,
  // which saves a cycle between SEARCH and DIVIDE.
  seq_divider #(
    .DW (DW),
    .VW (16)
  ) u_div (
    .clock      (clock),
    .reset      (reset),
    .i_start    (w_last),
    .i_dividend ({r_p, {FRAC_BITS{1'b0}}}),
    .i_divisor  (w_best_next),
    .o_done     (w_div_done),
    .o_quotient (w_quotient)
  );

  assign w_ratio_sat = (|w_quotient[DW-1:16]) ? 16'hFFFF : w_quotient[15:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_p         <= '0;
      r_last      <= '0;
      r_have      <= 1'b0;
      r_oor       <= 1'b0;
      r_idx       <= '0;
      r_best      <= '0;
      r_best_dist <= '1;
      r_target    <= '0;
      r_ratio     <= UNITY_RATIO;
      r_valid     <= 1'b0;
      r_oor_out   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (period_en && !w_repeat) begin
            r_p <= period_in;
            if (w_in_range) begin
              r_oor       <= 1'b0;
              r_idx       <= '0;
              r_best_dist <= '1;
              r_state     <= ST_SEARCH;
            end else begin
              r_oor   <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_SEARCH: begin
          if (w_take) begin
            r_best      <= w_entry;
            r_best_dist <= w_dist;
          end
          if (w_last) begin
            r_state <= ST_DIVIDE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DIVIDE: begin
          if (w_div_done) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_target  <= r_oor ? r_p : r_best;
          r_ratio   <= r_oor ? UNITY_RATIO : w_ratio_sat;
          r_oor_out <= r_oor;
          r_valid   <= 1'b1;
          r_last    <= r_p;
          r_have    <= 1'b1;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign target_period = r_target;
  assign ratio         = r_ratio;
  assign ratio_valid   = r_valid;
  assign out_of_range  = r_oor_out;
  assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pitch_snap.sv
// Scoreboard bench for pitch_snap: stimulus predicts each conversion from the note table and timing rules,
// a monitor sampling just after each clock edge checks every ratio_valid pulse and busy against it.
module tb_pitch_snap;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] period_in = '0;
  logic        period_en = 1'b0;
  logic [15:0] target_period;
  logic [15:0] ratio;
  logic        ratio_valid;
  logic        out_of_range;
  logic        busy;

  pitch_snap dut (
    .clock         (clock),
    .reset         (reset),
    .period_in     (period_in),
    .period_en     (period_en),
    .target_period (target_period),
    .ratio         (ratio),
    .ratio_valid   (ratio_valid),
    .out_of_range  (out_of_range),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    logic [15:0] tgt;
    logic [15:0] rat;
    logic        oor;
    int          at;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 1'b0;

  // Model state: when the block can next capture, and the span of edges after which busy is high.
  int          m_free    = 0;
  int          m_busy_lo = 0;
  int          m_busy_hi = -1;
  bit          m_have    = 1'b0;
  logic [15:0] m_last    = '0;
  int          last_cap  = 0;

  int note_tab [12] = '{256, 242, 228, 216, 203, 192, 181, 171, 161, 152, 144, 136};

  function automatic exp_t model(input logic [15:0] p, input int c);
    exp_t   x;
    int     best;
    int     bd;
    int     d;
    longint q;
    if (p < 16 || p > 4000) begin
      x.tgt = p;
      x.rat = 16'h1000;
      x.oor = 1'b1;
      x.at  = c + 1;
    end else begin
      best = 0;
      bd   = (p > note_tab[0]) ? p - note_tab[0] : note_tab[0] - p;
      for (int i = 1; i < 12; i++) begin
        d = (p > note_tab[i]) ? p - note_tab[i] : note_tab[i] - p;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
      q     = (longint'(p) * 4096) / longint'(note_tab[best]);
      x.tgt = 16'(note_tab[best]);
      x.rat = (q > 65535) ? 16'hFFFF : 16'(q);
      x.oor = 1'b0;
      x.at  = c + 41;
    end
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step(input bit en, input logic [15:0] p);
    exp_t x;
    int   e;
    @(negedge clock);
    reset     = 1'b0;
    period_en = en;
    period_in = p;
    e = cyc + 1;
    if (en && e >= m_free && !(m_have && p == m_last)) begin
      x = model(p, e);
      sbq.push_back(x);
      m_have    = 1'b1;
      m_last    = p;
      m_busy_lo = e;
      m_busy_hi = x.oor ? e : e + 40;
      m_free    = m_busy_hi + 2;
      last_cap  = e;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset     = 1'b1;
    period_en = 1'b0;
    sbq.delete();
    m_have    = 1'b0;
    m_busy_hi = -1;
    m_free    = cyc + 2;
    @(posedge clock);
    #1;
    check("reset target_period", 32'(target_period), 32'd0);
    check("reset ratio", 32'(ratio), 32'h1000);
    check("reset ratio_valid", 32'(ratio_valid), 32'd0);
    check("reset out_of_range", 32'(out_of_range), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
  endtask

  // Monitor: checks busy every cycle, flags missed pulses, and compares each pulse with the queue head.
  always @(posedge clock) begin
    exp_t x;
    #1;
    if (mon_on && !reset) begin
      check("busy", 32'(busy), 32'(cyc >= m_busy_lo && cyc <= m_busy_hi));
      while (sbq.size() > 0 && sbq[0].at < cyc) begin
        x = sbq.pop_front();
        checks++;
        errors++;
        $display("FAIL missed pulse: got none required pulse at cycle %0d", x.at);
      end
      if (ratio_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected pulse: got ratio_valid at cycle %0d required none", cyc);
        end else begin
          x = sbq.pop_front();
          check("pulse cycle", 32'(cyc), 32'(x.at));
          check("target_period", 32'(target_period), 32'(x.tgt));
          check("ratio", 32'(ratio), 32'(x.rat));
          check("out_of_range", 32'(out_of_range), 32'(x.oor));
        end
      end
    end
  end

  function automatic logic [15:0] pick_value();
    int sel;
    sel = $urandom_range(0, 5);
    case (sel)
      0:       return 16'($urandom_range(16, 300));
      1:       return 16'(note_tab[$urandom_range(0, 11)] + $urandom_range(0, 4) - 2);
      2: begin
        case ($urandom_range(0, 3))
          0:       return 16'd15;
          1:       return 16'd16;
          2:       return 16'd4000;
          default: return 16'd4001;
        endcase
      end
      3:       return 16'd0;
      4:       return 16'($urandom_range(0, 65535));
      default: return 16'($urandom_range(16, 4000));
    endcase
  endfunction

  initial begin
    logic [15:0] p;
    int          cap;

    do_reset();
    mon_on = 1'b1;

    // Gated: period_in toggles but period_en stays low.
    for (int i = 0; i < 20; i++) step(1'b0, 16'($urandom_range(16, 4000)));

    // Nominal snap, then held value exercises repeat suppression.
    repeat (60) step(1'b1, 16'd139);
    // Equidistant from 144 and 136.
    repeat (50) step(1'b1, 16'd140);
    // Out of range both ends.
    repeat (5) step(1'b1, 16'd0);
    repeat (5) step(1'b1, 16'd5000);
    repeat (50) step(1'b1, 16'd150);

    // Reset in the middle of the divide, then the same value reconverts.
    step(1'b1, 16'd200);
    cap = last_cap;
    while (cyc < cap + 18) step(1'b1, 16'd200);
    do_reset();
    repeat (50) step(1'b1, 16'd200);

    // Randomized traffic, including period_en dropping mid-conversion.
    p = 16'd139;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 8) p = pick_value();
      step($urandom_range(0, 19) != 0, p);
    end

    repeat (60) step(1'b0, p);
    check("scoreboard drained", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish by cycle %0d required finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pitch_snap.md
# pitch_snap

Downstream of the period detector in the autotune path. Takes the measured zero-crossing period (in clock cycles) and finds the nearest entry in a fixed table of target note periods. It then computes the resampling ratio, measured/target, in unsigned Q4.12. The resampler consumes this ratio as its read-pointer step, so output pitch lands on the snapped note.

## Interface
- NUM_NOTES, 12: number of entries in the target period table.
- FRAC_BITS, 12: fractional bits of ratio; the ratio word is 16 bits.
- MIN_PERIOD, 16: smallest accepted period_in; below this the input is out of range.
- MAX_PERIOD, 4000: largest accepted period_in; above this the input is out of range.
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- period_in  in  16  measured period in clock cycles, from the period detector.
- period_en  in  1  level; high once upstream has produced a valid period. Stays high thereafter.
- target_period  out  16  snapped note period for the last conversion.
- ratio  out  16  Q4.12 ratio, computed as period_in / target_period.
- ratio_valid  out  1  one-cycle pulse when target_period, ratio and out_of_range update.
- out_of_range  out  1  high if the last conversion rejected its input.
- busy  out  1  high in any state other than IDLE.

## Operation
- State machine: IDLE → SEARCH → DIVIDE → DONE → IDLE.
- **IDLE**
  - Nothing happens while period_en is low.
  - When period_en is high, period_in is captured into p.
  - If the result is valid and p equals the last captured value, the block stays in IDLE. There is no pulse (repeat suppression).
  - If p == 0, p < MIN_PERIOD or p > MAX_PERIOD, the block goes to DONE with target_period = p, ratio = 0x1000 (unity) and out_of_range = 1.
  - Otherwise the block goes to SEARCH.
- **SEARCH**
  - One table entry is examined per cycle, index 0 to NUM_NOTES-1.
  - The distance is |p − entry|, computed in 17 bits.
  - The best entry is replaced only when the new distance is strictly smaller. A tie therefore keeps the lower index.
- **DIVIDE**
  - Restoring division of {p, FRAC_BITS zeros} (28 bits) by the best entry.
  - One quotient bit per cycle; 28 cycles.
  - If any quotient bit above bit 15 is set, ratio saturates to 0xFFFF.
  - The quotient is truncated, not rounded.
- **DONE**
  - Registers target_period, ratio and out_of_range.
  - Pulses ratio_valid.
  - Records p as the last captured value and sets the result-valid flag.
  - Returns to IDLE.
- period_in changes while busy are ignored. The next capture happens on the first IDLE cycle.
- Table contents are descending, nonzero, and at most MAX_PERIOD.

## Timing
- A capture at cycle 0 in IDLE gives ratio_valid at cycle NUM_NOTES+29. With defaults that is cycle 41.
- An out-of-range capture at cycle 0 gives ratio_valid at cycle 1.
- While period_en stays high and period_in keeps changing, the minimum spacing between ratio_valid pulses is NUM_NOTES+30 cycles.
- Outputs hold their value between pulses.
- Reset values:
  - target_period = 0
  - ratio = 0x1000
  - ratio_valid = 0
  - out_of_range = 0
  - busy = 0
  - state = IDLE
  - result-valid flag cleared
- Reset in any state, including mid-DIVIDE, takes effect on the next edge. The aborted conversion produces no pulse.
- period_en dropping mid-conversion does not abort it. The block re-arms only when period_en is high in IDLE.

## Structure
- Package pitch_pkg holds:
  - the NOTE_TABLE constant array of 16-bit periods (descending), including adjacent entries 144 and 136;
  - UNITY_RATIO = 16'h1000;
  - the state enum.
- Sub-module seq_divider: 28-bit dividend, 16-bit divisor, start/done handshake, 28-cycle restoring divider.
- pitch_snap contains the FSM, the search comparator, the capture and repeat-suppression registers, and the saturation logic.

## Test plan
- **Nominal snap:** period_en=1, period_in=139 → at cycle 41: ratio_valid=1, target_period=136, ratio=4186 (0x105A), out_of_range=0.
- **Tie to lower index:** period_in=140 (equidistant from 144 and 136) → target_period=144, ratio=3982.
- **Out of range:** period_in=0, then 5000 → ratio_valid at cycle 1 in each case, ratio=0x1000, out_of_range=1, target_period equal to the input.
- **Repeat suppression:** hold period_in=139 after the first result → no further ratio_valid. Change to 150 → a new pulse 41 cycles after capture.
- **Reset mid-DIVIDE:** assert reset at cycle 20 after capture → no ratio_valid, all outputs at reset values, busy=0. The same period_in then reconverts in full.
- **Gated start:** period_en=0 with period_in toggling → busy stays 0 and no pulses. Raise period_en → capture on that cycle.
